// File: rtl/np_uart_rx.sv
// UART receiver: 2-flop synchronized line, 8N1 framing FSM, small valid/ready FIFO.
// Define NP_UART_RX_PARITY_EN to add an even-parity bit (8E1) and the PARITY_ERR output.
module np_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 106,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SERIAL_RX,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
`ifdef NP_UART_RX_PARITY_EN
  output logic       PARITY_ERR,
`endif
  output logic       BUSY
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_e;

  logic             sync1_q, rxs_q, rxs_prev_q;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shreg_q;
  logic             frame_err_q, overrun_q;
  logic             push_req, pop, wr_en, empty, full;
  logic [AW:0]      wr_q, rd_q;
  logic [7:0]       mem [FIFO_DEPTH];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= SERIAL_RX;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

`ifdef NP_UART_RX_PARITY_EN
  logic par_q, parity_err_q;
  assign push_req = (state_q == S_STOP) && (cnt_q == '0) && rxs_q && !(^{shreg_q, par_q});
  assign PARITY_ERR = parity_err_q;
`else
  assign push_req = (state_q == S_STOP) && (cnt_q == '0) && rxs_q;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
`ifdef NP_UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
`ifdef NP_UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (!rxs_q && rxs_prev_q) begin
            cnt_q   <= HALF_LOAD;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (cnt_q == '0) begin
            if (rxs_q) begin
              state_q <= S_IDLE;
            end else begin
              cnt_q     <= FULL_LOAD;
              bit_idx_q <= '0;
              state_q   <= S_DATA;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == '0) begin
            shreg_q <= {rxs_q, shreg_q[7:1]};
            cnt_q   <= FULL_LOAD;
            if (bit_idx_q == 3'd7) begin
`ifdef NP_UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`ifdef NP_UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_q == '0) begin
            par_q   <= rxs_q;
            cnt_q   <= FULL_LOAD;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (cnt_q == '0) begin
            if (rxs_q) begin
              // A bad stop bit outranks parity, so parity is only judged here.
`ifdef NP_UART_RX_PARITY_EN
              parity_err_q <= ^{shreg_q, par_q};
`endif
              state_q <= S_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (rxs_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = !empty && RX_READY;
  assign wr_en = push_req && (!full || pop);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_q      <= '0;
      rd_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      overrun_q <= push_req && full && !pop;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_q[AW-1:0]] <= shreg_q;
  end

  assign RX_VALID  = !empty;
  assign RX_DATA   = empty ? '0 : mem[rd_q[AW-1:0]];
  assign FRAME_ERR = frame_err_q;
  assign OVERRUN   = overrun_q;
  assign BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_np_uart_rx.sv
// Scoreboard bench for np_uart_rx: stimulus queues expected bytes, a negedge monitor pops and compares.
module tb_np_uart_rx;

  localparam int unsigned CPB   = 106;
  localparam int unsigned DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       SERIAL_RX;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_READY;
  logic       FRAME_ERR;
  logic       OVERRUN;
  logic       BUSY;
`ifdef NP_UART_RX_PARITY_EN
  logic       PARITY_ERR;
`endif

  np_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .SERIAL_RX(SERIAL_RX),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN),
`ifdef NP_UART_RX_PARITY_EN
    .PARITY_ERR(PARITY_ERR),
`endif
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, valid_cycles = 0, rx_cnt = 0;
  logic [7:0]  exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      if (FRAME_ERR) fe_cnt++;
      if (OVERRUN)   ov_cnt++;
`ifdef NP_UART_RX_PARITY_EN
      if (PARITY_ERR) pe_cnt++;
`endif
      if (RX_VALID) valid_cycles++;
      if (RX_VALID && RX_READY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte got %0h expected none", RX_DATA);
        end else begin
          chk("rx_data", {24'd0, RX_DATA}, {24'd0, exp_q.pop_front()});
          rx_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bit_time(input logic v);
    SERIAL_RX = v;
    repeat (CPB) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef NP_UART_RX_PARITY_EN
    bit_time(^d);
`endif
    bit_time(stop);
  endtask

`ifdef NP_UART_RX_PARITY_EN
  task automatic send_par_frame(input logic [7:0] d, input logic par);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    bit_time(par);
    bit_time(1'b1);
  endtask
`endif

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rx_valid"}, {31'd0, RX_VALID}, 32'd0);
    chk({tag, "_rx_data"}, {24'd0, RX_DATA}, 32'd0);
    chk({tag, "_frame_err"}, {31'd0, FRAME_ERR}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, OVERRUN}, 32'd0);
    chk({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
  endtask

  int unsigned v0, o0, f0, r0, p0;

  initial begin
    RST = 1'b0;
    SERIAL_RX = 1'b1;
    RX_READY = 1'b0;
    repeat (3) tick();
    chk_zero_outputs("reset");
    RST = 1'b1;
    repeat (10) tick();

    // single byte, consumer always ready
    RX_READY = 1'b1;
    exp_q.push_back(8'h41);
    v0 = valid_cycles;
    send_frame(8'h41, 1'b1);
    repeat (20) tick();
    chk("t1_valid_cycles", valid_cycles - v0, 32'd1);
    chk("t1_frame_err_cnt", fe_cnt, 32'd0);
    chk("t1_overrun_cnt", ov_cnt, 32'd0);
    chk("t1_queue_left", exp_q.size(), 32'd0);

    // fill FIFO, then overrun
    RX_READY = 1'b0;
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    chk("t2_valid_full", {31'd0, RX_VALID}, 32'd1);
    chk("t2_head", {24'd0, RX_DATA}, 32'h00);
    o0 = ov_cnt;
    send_frame(8'h7E, 1'b1);
    repeat (20) tick();
    chk("t2_overrun_pulses", ov_cnt - o0, 32'd1);
    RX_READY = 1'b1;
    repeat (10) tick();
    chk("t2_valid_drained", {31'd0, RX_VALID}, 32'd0);
    chk("t2_data_drained", {24'd0, RX_DATA}, 32'd0);
    chk("t2_queue_left", exp_q.size(), 32'd0);

    // 20-clock low glitch
    r0 = rx_cnt;
    f0 = fe_cnt;
    SERIAL_RX = 1'b0;
    repeat (10) tick();
    chk("t3_busy_glitch", {31'd0, BUSY}, 32'd1);
    repeat (10) tick();
    SERIAL_RX = 1'b1;
    repeat (CPB) tick();
    chk("t3_busy_after", {31'd0, BUSY}, 32'd0);
    chk("t3_no_byte", rx_cnt - r0, 32'd0);
    chk("t3_no_frame_err", fe_cnt - f0, 32'd0);

    // bad stop bit followed by a 500-clock break
    f0 = fe_cnt;
    send_frame(8'h33, 1'b0);
    repeat (500) tick();
    SERIAL_RX = 1'b1;
    repeat (2 * CPB) tick();
    chk("t4_frame_err_pulses", fe_cnt - f0, 32'd1);
    chk("t4_no_push", rx_cnt - r0, 32'd0);
    exp_q.push_back(8'h34);
    send_frame(8'h34, 1'b1);
    repeat (20) tick();
    chk("t4_queue_left", exp_q.size(), 32'd0);

    // reset during bit 4 of 0xC3
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b1);
    bit_time(1'b0);
    bit_time(1'b0);
    SERIAL_RX = 1'b0;
    repeat (CPB / 2) tick();
    RST = 1'b0;
    tick();
    chk_zero_outputs("midreset");
    repeat (2) tick();
    SERIAL_RX = 1'b1;
    tick();
    RST = 1'b1;
    repeat (3 * CPB) tick();
    chk("t5_busy_idle", {31'd0, BUSY}, 32'd0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    repeat (20) tick();
    chk("t5_queue_left", exp_q.size(), 32'd0);

`ifdef NP_UART_RX_PARITY_EN
    exp_q.push_back(8'h07);
    send_par_frame(8'h07, 1'b1);
    repeat (20) tick();
    chk("t6_good_parity", exp_q.size(), 32'd0);
    p0 = pe_cnt;
    r0 = rx_cnt;
    send_par_frame(8'h07, 1'b0);
    repeat (20) tick();
    chk("t6_parity_err_pulses", pe_cnt - p0, 32'd1);
    chk("t6_no_push", rx_cnt - r0, 32'd0);
    chk("total_bytes", rx_cnt, 32'd8);
`else
    p0 = pe_cnt;
    chk("total_bytes", rx_cnt + p0, 32'd7);
`endif
    chk("total_frame_err", fe_cnt, 32'd1);
    chk("total_overrun", ov_cnt, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/np_uart_rx.md
Name: np_uart_rx

Overview:
- Synthesizable UART receiver that consumes the SoC serial-transmit line (SERIAL_TX) and turns it into bytes; the downstream stage of the SoC's UART output.
- Used by the top-level bench as a checker and by np_top for loopback and self-test.
- Frames are 8N1 (optionally 8E1), LSB first, idle-high line.
- Received bytes are buffered in a small FIFO and leave through a valid/ready interface.

Parameters:
- CLKS_PER_BIT, 106: clock cycles per bit period. Minimum 4. Half-bit point is CLKS_PER_BIT/2, truncated.
- FIFO_DEPTH, 4: receive FIFO entries. Power of two, 2..16.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  asynchronous active-low reset.
- SERIAL_RX  in  1  asynchronous serial line, idle high.
- RX_DATA  out  8  byte at the FIFO head.
- RX_VALID  out  1  FIFO not empty.
- RX_READY  in  1  consumer accepts RX_DATA when RX_VALID and RX_READY are both high.
- FRAME_ERR  out  1  one-cycle pulse when a stop bit is sampled low.
- OVERRUN  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
- BUSY  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: RX_DATA=0, RX_VALID=0, FRAME_ERR=0, OVERRUN=0, BUSY=0. FIFO empty, FSM in IDLE, synchronizer flops set to 1.
- Input conditioning: 2-flop synchronizer on SERIAL_RX; rxs is the synchronized output. The edge detector compares rxs with its previous value.
- IDLE: a falling edge on rxs loads the bit counter with CLKS_PER_BIT/2 - 1 and enters START.
- START: when the counter reaches 0, sample rxs.
  - rxs = 1: false start, return to IDLE, no flags.
  - rxs = 0: load CLKS_PER_BIT - 1, set bit index to 0, enter DATA.
- DATA: sample rxs each time the counter reaches 0, then shift it into the shift register MSB side (LSB-first line order).
  - After 8 samples, enter STOP (or PARITY when the optional feature is enabled).
- STOP: sample at mid-bit.
  - 1: push the byte to the FIFO, go to IDLE.
  - 0: pulse FRAME_ERR, drop the byte, enter WAIT_IDLE.
- WAIT_IDLE: stay until rxs = 1, then go to IDLE. A break condition produces exactly one FRAME_ERR.
- Push latency: RX_VALID rises on the cycle after the stop-bit sample when the FIFO was empty.
- FIFO rules:
  - Pop when RX_VALID and RX_READY; RX_DATA then shows the next entry in the following cycle.
  - Push while full with no pop in the same cycle: drop the byte, pulse OVERRUN, leave existing contents unchanged.
  - Push and pop in the same cycle while full: both succeed, no OVERRUN.
  - Push and pop in the same cycle while empty: the byte becomes visible the next cycle; RX_VALID was 0, so no pop occurs.
  - Read/write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full = MSBs differ and the lower bits are equal.
- RX_DATA is 0 when the FIFO is empty and is not X after reset.
- Reset mid-frame: everything returns to reset values immediately. The partial byte is discarded, and the next falling edge starts a fresh frame.
- Flags are never asserted in the same cycle as reset deassertion.

Optional Feature:
- Macro: NP_UART_RX_PARITY_EN.
- Defined:
  - A PARITY state between DATA and STOP samples a 9th bit.
  - Even parity is checked: XOR of the 8 data bits and the parity bit must be 0.
  - On mismatch, the byte is dropped at STOP and a PARITY_ERR output (1 bit, one-cycle pulse, reset 0) fires at the stop sample. This happens only if the stop bit is good; a bad stop bit takes precedence and only FRAME_ERR fires.
- Undefined: no PARITY state, no PARITY_ERR port, 8N1 framing only.

Test Plan:
- Send 0x41 with CLKS_PER_BIT=106 (bit = 106 clocks), RX_READY=1 -> RX_VALID high for one cycle with RX_DATA=0x41; no flags.
- Send 0x00, 0xFF, 0x55, 0xAA back-to-back with RX_READY=0 and FIFO_DEPTH=4 -> FIFO holds all four. A fifth byte 0x7E -> OVERRUN pulses once. Draining then yields 0x00, 0xFF, 0x55, 0xAA in order, and RX_VALID drops after the 4th pop.
- Low glitch of 20 clocks on an idle line -> no byte, no flags; BUSY high during the glitch, then low.
- Frame 0x33 with the stop bit forced low, line then held low for 500 clocks -> exactly one FRAME_ERR and no push. A following good 0x34 is received correctly.
- Assert RST low for 3 cycles during bit 4 of 0xC3, then send 0x5A -> only 0x5A appears; outputs are 0 during reset.
- With NP_UART_RX_PARITY_EN: send 0x07 with parity 1 -> accepted. Send 0x07 with parity 0 -> PARITY_ERR pulses and no push.
